// File: rtl/five_behave.sv
// -----------------------------------------------------------------------------
// five_behave
//
// Registered unsigned adder with carry and magnitude-compare flags.
// Every rising clock edge samples a 3-bit operand A and a 4-bit operand B.
// One edge later the block presents their widened sum, a carry flag and an
// A > B flag. All three outputs come from the same sample.
//
// Ports
//   clk    in   1   system clock, rising-edge active
//   rst_n  in   1   asynchronous active-low reset; clears all outputs at once
//   A      in   3   unsigned operand, 0..7
//   B      in   4   unsigned operand, 0..15
//   C      out  5   registered sum A + B, 0..22
//   C1     out  1   registered carry out of a 4-bit add (sum >= 16)
//   C2     out  1   registered unsigned compare flag, A > B
// -----------------------------------------------------------------------------
module five_behave (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [2:0] A,
   input  logic [3:0] B,
   output logic [4:0] C,
   output logic       C1,
   output logic       C2
);

   // Both operands are zero-extended to the sum width. The largest result,
   // 7 + 15 = 22, fits in 5 bits, so the add never wraps.
   logic [4:0] a_ext;
   logic [4:0] b_ext;
   logic [4:0] sum_next;
   logic       carry_next;
   logic       gt_next;

   logic [4:0] sum_reg;
   logic       carry_reg;
   logic       gt_reg;

   always_comb begin
      a_ext      = {2'b00, A};
      b_ext      = {1'b0, B};
      sum_next   = a_ext + b_ext;
      // Bit 4 of the widened sum is the carry out of a 4-bit add.
      carry_next = sum_next[4];
      // Equality gives 0. Comparing at 5 bits keeps both sides unsigned
      // and the same width.
      gt_next    = (a_ext > b_ext);
   end

   // The three results share one register stage. This keeps C, C1 and C2
   // consistent with each other. It also leaves no combinational path from
   // the inputs to any output.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_reg   <= 5'd0;
         carry_reg <= 1'b0;
         gt_reg    <= 1'b0;
      end else begin
         sum_reg   <= sum_next;
         carry_reg <= carry_next;
         gt_reg    <= gt_next;
      end
   end

   assign C  = sum_reg;
   assign C1 = carry_reg;
   assign C2 = gt_reg;

endmodule

// File: tb/tb_five_behave.sv
// -----------------------------------------------------------------------------
// tb_five_behave
//
// Self-checking bench for five_behave. The directed vectors are listed in a
// table. Each vector's expected result goes into a queue when the vector is
// driven. The result is popped and compared one clock edge later. A random
// sweep checks against a small arithmetic model. Separate hand-written
// sequences cover reset, and a reset that arrives between clock edges.
// -----------------------------------------------------------------------------
module tb_five_behave;

   logic       clk;
   logic       rst_n;
   logic [2:0] A;
   logic [3:0] B;
   logic [4:0] C;
   logic       C1;
   logic       C2;

   five_behave dut (
      .clk   (clk),
      .rst_n (rst_n),
      .A     (A),
      .B     (B),
      .C     (C),
      .C1    (C1),
      .C2    (C2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] a;
      logic [3:0] b;
      logic [4:0] c;
      logic       c1;
      logic       c2;
   } vec_t;

   typedef struct {
      logic [4:0] c;
      logic       c1;
      logic       c2;
   } exp_t;

   exp_t scoreboard[$];
   vec_t table_v[9];

   int n_checks = 0;
   int n_fail   = 0;

   exp_t last_exp;

   task automatic check(input string name, input logic [4:0] got,
                        input logic [4:0] want);
      n_checks++;
      if (got !== want) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d", name, got, want);
      end
   endtask

   task automatic check_outputs(input string name, input exp_t e);
      check({name, ".C"},  C,          e.c);
      check({name, ".C1"}, {4'd0, C1}, {4'd0, e.c1});
      check({name, ".C2"}, {4'd0, C2}, {4'd0, e.c2});
   endtask

   // Drive one sample at the falling edge and push its expected result.
   // Before the rising edge, the outputs must still show the previous result.
   // At the following falling edge, pop the expected result and compare.
   task automatic step(input logic [2:0] a, input logic [3:0] b, input exp_t e,
                       input logic check_hold);
      exp_t got_e;
      A = a;
      B = b;
      scoreboard.push_back(e);
      #1;
      if (check_hold)
         check_outputs("hold_before_edge", last_exp);
      @(posedge clk);
      @(negedge clk);
      if (scoreboard.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL scoreboard: empty queue, expected an entry");
      end else begin
         got_e = scoreboard.pop_front();
         check_outputs($sformatf("A=%0d B=%0d", a, b), got_e);
         $display("txn A=%0d B=%0d -> C=%0d C1=%0b C2=%0b (exp %0d %0b %0b)",
                  a, b, C, C1, C2, got_e.c, got_e.c1, got_e.c2);
      end
      last_exp = e;
   endtask

   function automatic exp_t model(input logic [2:0] a, input logic [3:0] b);
      exp_t e;
      int s;
      s    = int'(a) + int'(b);
      e.c  = s[4:0];
      e.c1 = (s >= 16);
      e.c2 = (int'(a) > int'(b));
      return e;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached, expected finish");
      $fatal(1, "timeout");
   end

   initial begin
      exp_t e;
      exp_t zero_e;
      zero_e.c  = 5'd0;
      zero_e.c1 = 1'b0;
      zero_e.c2 = 1'b0;

      //          a     b      c      c1    c2
      table_v[0] = '{3'd2, 4'd8,  5'd10, 1'b0, 1'b0};
      table_v[1] = '{3'd5, 4'd15, 5'd20, 1'b1, 1'b0};
      table_v[2] = '{3'd5, 4'd4,  5'd9,  1'b0, 1'b1};
      table_v[3] = '{3'd4, 4'd4,  5'd8,  1'b0, 1'b0};
      table_v[4] = '{3'd0, 4'd0,  5'd0,  1'b0, 1'b0};
      table_v[5] = '{3'd1, 4'd15, 5'd16, 1'b1, 1'b0};
      table_v[6] = '{3'd0, 4'd15, 5'd15, 1'b0, 1'b0};
      table_v[7] = '{3'd7, 4'd0,  5'd7,  1'b0, 1'b1};
      table_v[8] = '{3'd7, 4'd15, 5'd22, 1'b1, 1'b0};

      // Reset with all-ones inputs: the outputs must stay at 0 across edges.
      rst_n = 1'b0;
      A     = 3'b111;
      B     = 4'b1111;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_outputs("reset_hold", zero_e);
      end
      last_exp = zero_e;
      rst_n    = 1'b1;

      // Directed table. The inputs change every cycle.
      for (int i = 0; i < 9; i++) begin
         e.c  = table_v[i].c;
         e.c1 = table_v[i].c1;
         e.c2 = table_v[i].c2;
         step(table_v[i].a, table_v[i].b, e, 1'b1);
      end

      // Random sweep, checked against the arithmetic model.
      for (int i = 0; i < 40; i++) begin
         logic [2:0] ra;
         logic [3:0] rb;
         ra = 3'($urandom_range(0, 7));
         rb = 4'($urandom_range(0, 15));
         step(ra, rb, model(ra, rb), 1'b1);
      end

      // Reset asserted between edges. Load a nonzero result first, then drop
      // rst_n after the rising edge. The outputs must clear before the next
      // edge arrives.
      step(3'd7, 4'd15, model(3'd7, 4'd15), 1'b1);
      A = 3'd6;
      B = 4'd3;
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_outputs("async_reset_clear", zero_e);
      scoreboard.delete();
      @(posedge clk);
      #1;
      check_outputs("async_reset_hold", zero_e);
      @(negedge clk);
      rst_n    = 1'b1;
      last_exp = zero_e;

      // After release, the first edge loads that edge's inputs and nothing
      // carries over from before the reset.
      step(3'd3, 4'd2, model(3'd3, 4'd2), 1'b1);
      step(3'd6, 4'd9, model(3'd6, 4'd9), 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
